seq_decoder_nx: RTL
===================

// Module: seq_decoder_nx
// PURPOSE
//   Parametrised, registered N-to-2^N one-hot decoder. Successor to the combinational 3x8 decoder.
//   Adds a valid/ready input handshake, an enable, output polarity selection and a SCAN mode.
//   In SCAN mode the active output walks through all 2^N lines, holding each for DWELL cycles.
//   Used as a select/strobe generator for banked peripherals and for LED/row scanning.
// PARAMETERS
//   N          3   address width; output width is 2^N
//   DWELL      4   cycles each line stays active in SCAN mode (must be >= 1)
//   ACTIVE_LOW 0   0: active line = 1, others 0; 1: active line = 0, others 1
// PORTS
//   clk       in   1    rising-edge clock
//   rst       in   1    asynchronous, active-high reset
//   en        in   1    block enable; 0 aborts any activity and blanks outputs
//   mode      in   1    sampled on accept: 0 = DECODE, 1 = SCAN
//   in_valid  in   1    address/request valid
//   in_ready  out  1    block can accept a request this cycle
//   a         in   N    address (DECODE) or start index (SCAN)
//   f         out  2^N  one-hot (or one-cold) select; f[k] is active when index == k
//   f_valid   out  1    1-cycle pulse whenever f takes a new active index
//   idx       out  N    index currently driven on f
//   busy      out  1    1 while in SCAN
// BEHAVIOUR
//   Reset (async, immediate): state=IDLE, f=all-inactive (0s, or 1s if ACTIVE_LOW), f_valid=0,
//     idx=0, busy=0. in_ready follows en once rst deasserts.
//   Accept = in_valid & in_ready at a rising edge. in_valid while in_ready=0 is ignored (not queued).
//   in_ready = en & (state != SCAN), combinational from registered state.
//   States: IDLE, DECODE, SCAN.
//   DECODE (mode=0 on accept):
//     - f = onehot(a), idx = a, f_valid = 1 at the next edge (latency 1 cycle).
//     - state=DECODE; f holds until the next accept, en=0 or rst.
//     - Back-to-back accepts every cycle are legal. f_valid pulses even if a repeats.
//   SCAN (mode=1 on accept):
//     - Next edge: idx = a, f = onehot(a), f_valid = 1, busy = 1, dwell counter = 1.
//     - Each edge: counter increments. When it reaches DWELL, idx = idx+1 mod 2^N (2^N-1 wraps to 0),
//       f updates, f_valid pulses, counter = 1.
//     - After 2^N indices (start..start-1 inclusive), each held DWELL cycles, state=IDLE:
//       f=all-inactive, busy=0, f_valid=0, idx unchanged.
//     - Total scan length = 2^N*DWELL cycles. DWELL=1 steps idx every cycle.
//   en=0 (any state): at the next edge state=IDLE, f=all-inactive, busy=0, f_valid=0.
//     An in-progress scan is discarded. en has priority over a simultaneous accept (in_ready is already 0).
//   Going DECODE->IDLE only happens through en=0. Accepting in DECODE reuses the normal accept path.
//   ACTIVE_LOW affects only the f drive. idx, f_valid and busy are always active-high.
//   Dwell counter width = $clog2(DWELL+1). No X on any output after reset.
// TESTING
//   1. N=3: rst pulse mid-cycle -> f=8'h00, f_valid=0, busy=0 immediately. a=3'b010 accepted ->
//      next cycle f=8'b0000_0100, idx=2, f_valid=1 for one cycle.
//   2. DECODE back-to-back: a=0,1,7,7 on 4 consecutive cycles -> f=01,02,80,80 (hex), each 1 cycle later.
//      f_valid high on all 4 cycles.
//   3. SCAN, DWELL=4, start a=6 -> idx 6,7,0,1..5, each held 4 cycles. Wrap 7->0 observed.
//      busy low and f=00 after 32 cycles. in_ready=0 throughout the scan.
//   4. Mid-scan: deassert en at idx=3 -> next cycle f=00, busy=0. Reassert en -> in_ready=1, new request accepted.
//   5. rst asserted during SCAN at idx=5 -> outputs cleared asynchronously. After release a DECODE request works normally.
//   6. ACTIVE_LOW=1, a=3'b101 -> f=8'b1101_1111. Idle and reset f=8'hFF.

Source files
------------

// File: rtl/seq_decoder_nx.sv
`default_nettype none
// seq_decoder_nx: registered N-to-2^N one-hot/one-cold decoder with a valid/ready request
// port, an enable, and a SCAN mode that walks every output line for DWELL cycles each.
module seq_decoder_nx #(
  parameter int N          = 3,
  parameter int DWELL      = 4,
  parameter int ACTIVE_LOW = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              mode,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [N-1:0]      a,
  output logic [2**N-1:0]   f,
  output logic              f_valid,
  output logic [N-1:0]      idx,
  output logic              busy
);

  localparam int W  = 2**N;
  localparam int CW = $clog2(DWELL + 1);
  localparam logic [W-1:0]  INACTIVE  = (ACTIVE_LOW != 0) ? {W{1'b1}} : {W{1'b0}};
  localparam logic [CW-1:0] DWELL_C   = CW'(DWELL);
  localparam logic [N-1:0]  LAST_STEP = {N{1'b1}};

  typedef enum logic [1:0] {IDLE, DECODE, SCAN} state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic [N-1:0]  steps, steps_nxt;
  logic [N-1:0]  idx_nxt;
  logic [W-1:0]  f_nxt;
  logic          fv_nxt;
  logic          accept;

  // Polarity is folded in here so the rest of the logic only deals with indices.
  function automatic logic [W-1:0] drive_line(input logic [N-1:0] k);
    logic [W-1:0] oh;
    oh = {{(W-1){1'b0}}, 1'b1} << k;
    return oh ^ INACTIVE;
  endfunction

  assign in_ready = en & (state != SCAN);
  assign accept   = in_valid & in_ready;
  assign busy     = (state == SCAN);

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    steps_nxt = steps;
    idx_nxt   = idx;
    f_nxt     = f;
    fv_nxt    = 1'b0;
    if (!en) begin
      state_nxt = IDLE;
      f_nxt     = INACTIVE;
    end else if (accept) begin
      state_nxt = mode ? SCAN : DECODE;
      idx_nxt   = a;
      f_nxt     = drive_line(a);
      fv_nxt    = 1'b1;
      cnt_nxt   = CW'(1);
      steps_nxt = '0;
    end else if (state == SCAN) begin
      if (cnt >= DWELL_C) begin
        cnt_nxt = CW'(1);
        // steps counts completed index changes; after the last one the walk has covered all lines
        if (steps == LAST_STEP) begin
          state_nxt = IDLE;
          f_nxt     = INACTIVE;
        end else begin
          steps_nxt = steps + 1'b1;
          idx_nxt   = idx + 1'b1;
          f_nxt     = drive_line(idx + 1'b1);
          fv_nxt    = 1'b1;
        end
      end else begin
        cnt_nxt = cnt + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      cnt     <= '0;
      steps   <= '0;
      idx     <= '0;
      f       <= INACTIVE;
      f_valid <= 1'b0;
    end else begin
      state   <= state_nxt;
      cnt     <= cnt_nxt;
      steps   <= steps_nxt;
      idx     <= idx_nxt;
      f       <= f_nxt;
      f_valid <= fv_nxt;
    end
  end

endmodule
`default_nettype wire
